// File: rtl/and_gate.sv
// Bitwise two-input AND cell with a registered copy of the result and a
// saturating counter of clock edges at which any result bit was high.
module and_gate #(
  parameter int WIDTH     = 1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [WIDTH-1:0]     c,
  output logic                 c_all,
  output logic                 c_any,
  output logic [WIDTH-1:0]     c_q,
  input  logic                 cnt_clr,
  output logic [CNT_WIDTH-1:0] hit_cnt
);

  // Continuous assigns keep the combinational outputs live with no clock
  // and propagate X/Z exactly as the & operator does.
  assign c     = a & b;
  assign c_all = &c;
  assign c_any = |c;

  always_ff @(posedge clk) begin
    if (rst) begin
      c_q <= '0;
    end else begin
      c_q <= c;
    end
  end

  // A clear wins over a hit on the same edge; the count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt <= '0;
    end else if (cnt_clr) begin
      hit_cnt <= '0;
    end else if (c_any && (hit_cnt != {CNT_WIDTH{1'b1}})) begin
      hit_cnt <= hit_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_and_gate.sv
// Bench for and_gate: a 1-bit instance and a 4-bit instance with a 2-bit
// counter, checked every cycle against a behavioural model plus literal pins.
module tb_and_gate;
  localparam int W4  = 4;
  localparam int CW4 = 2;
  localparam int CW1 = 16;

  // Clock / reset
  logic clk     = 1'b0;
  logic clk_run = 1'b0;
  logic rst     = 1'b1;
  logic cnt_clr = 1'b0;

  always #5 if (clk_run) clk = ~clk;

  // DUT signals
  logic [W4-1:0]  a4 = '0, b4 = '0;
  logic [W4-1:0]  c4, cq4;
  logic           c4_all, c4_any;
  logic [CW4-1:0] hit4;

  logic           a1 = 1'b0, b1 = 1'b0;
  logic           c1, c1_all, c1_any, cq1;
  logic [CW1-1:0] hit1;

  and_gate #(.WIDTH(W4), .CNT_WIDTH(CW4)) u_dut4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .c(c4), .c_all(c4_all),
    .c_any(c4_any), .c_q(cq4), .cnt_clr(cnt_clr), .hit_cnt(hit4)
  );

  and_gate #(.WIDTH(1), .CNT_WIDTH(CW1)) u_dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .c(c1), .c_all(c1_all),
    .c_any(c1_any), .c_q(cq1), .cnt_clr(cnt_clr), .hit_cnt(hit1)
  );

  // Scoreboard counters
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: registered result and hit count as plain integers.
  int  m4_cq = 0, m4_cnt = 0, m1_cq = 0, m1_cnt = 0;
  bit  chk_en = 1'b0;

  function automatic int sat_inc(input int v, input int cw);
    int top;
    top = (1 << cw) - 1;
    return (v + 1 > top) ? top : v + 1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m4_cq = 0; m4_cnt = 0; m1_cq = 0; m1_cnt = 0;
    end else begin
      m4_cq = int'(a4 & b4);
      m1_cq = int'(a1 & b1);
      if (cnt_clr) begin
        m4_cnt = 0;
        m1_cnt = 0;
      end else begin
        if ((a4 & b4) != 0) m4_cnt = sat_inc(m4_cnt, CW4);
        if ((a1 & b1) != 0) m1_cnt = sat_inc(m1_cnt, CW1);
      end
    end
  end

  // Compare process: outputs sampled on the falling edge, before new stimulus.
  always @(negedge clk) begin
    if (chk_en) begin
      check("c4",      c4,     a4 & b4);
      check("c4_all",  c4_all, (a4 & b4) == 4'hF);
      check("c4_any",  c4_any, (a4 & b4) != 0);
      check("cq4",     cq4,    m4_cq);
      check("hit4",    hit4,   m4_cnt);
      check("c1",      c1,     a1 & b1);
      check("c1_all",  c1_all, a1 & b1);
      check("c1_any",  c1_any, a1 & b1);
      check("cq1",     cq1,    m1_cq);
      check("hit1",    hit1,   m1_cnt);
    end
  end

  // Driver tasks
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_both(input logic [W4-1:0] va, input logic [W4-1:0] vb);
    a4 = va;
    b4 = vb;
    a1 = va[0];
    b1 = vb[0];
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] tt_exp;
    int         sat_exp [5];

    // Truth table with no clock running, 10 ns per step.
    tt_exp = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      a1 = i[1];
      b1 = i[0];
      #1;
      check("tt_c",     c1,     tt_exp[i]);
      check("tt_c_all", c1_all, tt_exp[i]);
      check("tt_c_any", c1_any, tt_exp[i]);
      #9;
    end

    // Operand X handling.
    a1 = 1'b0; b1 = 1'bx; #1;
    check("x_a0", c1, 1'b0);
    a1 = 1'b1; #1;
    check("x_a1", c1, b1);
    #8;

    // Four-bit pattern, still unclocked.
    a4 = 4'b1100; b4 = 4'b1010; #1;
    check("pat_c",     c4,     4'b1000);
    check("pat_c_any", c4_any, 1'b1);
    check("pat_c_all", c4_all, 1'b0);
    a4 = 4'hF; b4 = 4'hF; #1;
    check("pat_all", c4_all, 1'b1);
    #8;

    // Start the clock under reset.
    drive_both(4'h0, 4'h0);
    rst = 1'b1;
    clk_run = 1'b1;
    tick();
    chk_en = 1'b1;
    check("rst_cq4",   cq4,  4'h0);
    check("rst_hit4",  hit4, 2'd0);
    rst = 1'b0;
    tick();
    check("idle_cq4",  cq4,  4'h0);
    check("idle_hit4", hit4, 2'd0);

    // Latency and saturation with CNT_WIDTH=2.
    drive_both(4'hF, 4'hF);
    check("lat_before", cq4, 4'h0);
    sat_exp = '{1, 2, 3, 3, 3};
    for (int i = 0; i < 5; i++) begin
      tick();
      check("lat_cq4", cq4,  4'hF);
      check("sat_hit4", hit4, sat_exp[i][CW4-1:0]);
    end
    cnt_clr = 1'b1;
    tick();
    check("clr_hit4", hit4, 2'd0);
    check("clr_cq4",  cq4,  4'hF);
    cnt_clr = 1'b0;

    // Reset mid-operation with the inputs held high.
    rst = 1'b1;
    tick();
    check("mid_rst_cq4",  cq4,  4'h0);
    check("mid_rst_hit4", hit4, 2'd0);
    check("mid_rst_cq1",  cq1,  1'b0);
    rst = 1'b0;
    tick();
    check("post_rst_cq4",  cq4,  4'hF);
    check("post_rst_hit4", hit4, 2'd1);
    check("post_rst_hit1", hit1, 16'd1);

    // Randomized traffic with occasional reset and clear.
    for (int n = 0; n < 400; n++) begin
      drive_both(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) a4 = 4'h0;
      rst     = ($urandom_range(0, 39) == 0);
      cnt_clr = ($urandom_range(0, 19) == 0);
      tick();
    end
    rst = 1'b0;
    cnt_clr = 1'b0;
    tick();
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
